// File: rtl/pwm_timebase_counter_if.sv
// PWM timebase bundle: run request and carrier setup in,
// carrier count and boundary pulses out.
interface pwm_timebase_counter_if #(
  parameter int COUNTER_WIDTH   = 16,
  parameter int PRESCALER_WIDTH = 8
);
  logic                       enable;
  logic [1:0]                 mode;
  logic [PRESCALER_WIDTH-1:0] prescale;
  logic [COUNTER_WIDTH-1:0]   period;
  logic [COUNTER_WIDTH-1:0]   counter_out;
  logic                       direction;
  logic                       period_start;
  logic                       top_reached;
  logic                       running;

  modport master (
    output enable,
    output mode,
    output prescale,
    output period,
    input  counter_out,
    input  direction,
    input  period_start,
    input  top_reached,
    input  running
  );

  modport slave (
    input  enable,
    input  mode,
    input  prescale,
    input  period,
    output counter_out,
    output direction,
    output period_start,
    output top_reached,
    output running
  );
endinterface

// File: rtl/pwm_timebase_counter.sv
// PWM carrier timebase: up / down / centre-aligned counter
// with prescaler and boundary pulses for shadow reloads.
module pwm_timebase_counter #(
  parameter int COUNTER_WIDTH   = 16,
  parameter int PRESCALER_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  pwm_timebase_counter_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [1:0] M_DOWN = 2'd1;
  localparam logic [1:0] M_UPDN = 2'd2;

  state_t                     r_state;
  logic [COUNTER_WIDTH-1:0]   r_cnt;
  logic                       r_dir;
  logic                       r_ps;
  logic                       r_top;
  logic                       r_run;
  logic [PRESCALER_WIDTH-1:0] r_pre;
  logic [1:0]                 r_mode;
  logic [COUNTER_WIDTH-1:0]   r_period;
  logic [PRESCALER_WIDTH-1:0] r_prescale;

  logic                       w_tick;
  logic                       w_is_dn;
  logic                       w_is_ud;
  logic [COUNTER_WIDTH-1:0]   w_inc;
  logic [COUNTER_WIDTH-1:0]   w_dec;
  logic [COUNTER_WIDTH-1:0]   w_nxt_cnt;
  logic                       w_nxt_dir;
  logic                       w_wrap;
  logic                       w_top;
  logic                       w_start_dn;

  assign w_tick     = (r_pre == r_prescale);
  assign w_is_dn    = (r_mode == M_DOWN);
  assign w_is_ud    = (r_mode == M_UPDN);
  assign w_inc      = r_cnt + 1'b1;
  assign w_dec      = r_cnt - 1'b1;
  assign w_start_dn = (bus.mode == M_DOWN);

  // Next carrier step for one prescaler tick.
  always_comb begin
    w_nxt_cnt = r_cnt;
    w_nxt_dir = r_dir;
    w_wrap    = 1'b0;
    w_top     = 1'b0;
    unique case (1'b1)
      w_is_dn: begin
        if (r_cnt == '0) begin
          w_nxt_cnt = r_period;
          w_wrap    = 1'b1;
        end else begin
          w_nxt_cnt = w_dec;
        end
      end
      w_is_ud: begin
        if (r_period == '0) begin
          w_nxt_cnt = '0;
          w_wrap    = 1'b1;
        end else if (!r_dir) begin
          w_nxt_cnt = w_inc;
          if (w_inc == r_period) begin
            w_nxt_dir = 1'b1;
            w_top     = 1'b1;
          end
        end else begin
          w_nxt_cnt = w_dec;
          if (w_dec == '0) begin
            w_nxt_dir = 1'b0;
            w_wrap    = 1'b1;
          end
        end
      end
      default: begin
        if (r_cnt == r_period) begin
          w_nxt_cnt = '0;
          w_wrap    = 1'b1;
        end else begin
          w_nxt_cnt = w_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dir      <= 1'b0;
      r_ps       <= 1'b0;
      r_top      <= 1'b0;
      r_run      <= 1'b0;
      r_pre      <= '0;
      r_mode     <= '0;
      r_period   <= '0;
      r_prescale <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ps  <= 1'b0;
          r_top <= 1'b0;
          if (bus.enable) begin
            r_state    <= S_RUN;
            r_run      <= 1'b1;
            r_ps       <= 1'b1;
            r_pre      <= '0;
            r_mode     <= bus.mode;
            r_period   <= bus.period;
            r_prescale <= bus.prescale;
            r_dir      <= w_start_dn;
            r_cnt      <= w_start_dn ? bus.period : '0;
          end
        end
        S_RUN: begin
          if (!bus.enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_ps    <= 1'b0;
            r_top   <= 1'b0;
            r_run   <= 1'b0;
            r_pre   <= '0;
          end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= w_nxt_cnt;
            r_dir <= w_nxt_dir;
            r_ps  <= w_wrap;
            r_top <= w_top;
            // Boundary: adopt the new carrier setup.
            if (w_wrap) begin
              r_mode     <= bus.mode;
              r_period   <= bus.period;
              r_prescale <= bus.prescale;
            end
          end else begin
            r_pre <= r_pre + 1'b1;
            r_ps  <= 1'b0;
            r_top <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.counter_out  = r_cnt;
  assign bus.direction    = r_dir;
  assign bus.period_start = r_ps;
  assign bus.top_reached  = r_top;
  assign bus.running      = r_run;

endmodule
